sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Upstream stage of the SHA-256 compression core. Accepts a message as a byte stream over a valid/ready handshake, performs FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length), and emits 512-bit message blocks for the core's message schedule. Flags the first and last block of each message, so the core knows when to load the IV and when the digest is final.

## Interface
Parameters:
- LEN_W, 61: width of the internal message byte counter. The length field is {byte_cnt, 3'b000}, zero-extended to 64 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  padder accepts a byte this cycle.
- in_data  in  8  message byte; the first byte lands in blk_data[511:504].
- in_last  in  1  this byte is the final byte of the message.
- blk_valid  out  1  blk_data/blk_first/blk_last valid.
- blk_ready  in  1  core consumes the block.
- blk_data  out  512  padded block, big-endian byte order.
- blk_first  out  1  block is the first of its message.
- blk_last  out  1  block is the final block of its message.

## Operation
- A byte transfers when in_valid && in_ready. A block transfers when blk_valid && blk_ready.
- State FILL (in_ready=1, blk_valid=0): write in_data into buffer byte index cnt (0..63), then cnt++ and byte_cnt++.
  - Not last, cnt reaches 64: go to OUT, next=FILL.
  - Last, message bytes in this block k ≤ 55: set byte k to 0x80, zero bytes k+1..55, write length into bytes 56..63. Go to OUT with blk_last=1, next=FILL.
  - Last, 56 ≤ k ≤ 63: set byte k to 0x80, zero the rest. Go to OUT with blk_last=0, next=TAIL (marker=0).
  - Last, k = 64: go to OUT with blk_last=0, next=TAIL (marker=1).
- State OUT (in_ready=0, blk_valid=1): blk_data and flags are held stable until the handshake. On handshake, clear the buffer, set cnt=0, and go to next.
- State TAIL (in_ready=0, blk_valid=0), one cycle: build a block with byte 0 = 0x80 if marker is set, else 0x00; zeros up to byte 55; length in bytes 56..63. Go to OUT with blk_last=1, next=FILL.
- blk_first is 1 for the first block emitted after reset or after a block with blk_last=1, and 0 otherwise.
- After the last block's handshake, byte_cnt clears and a new message starts.
- byte_cnt wraps modulo 2^LEN_W. No error is flagged.
- A message must contain ≥1 byte unless SHA256_PAD_EMPTY_MSG_EN is defined.

## Timing
- Reset values: in_ready=0 while rst_n is low, then 1 from the first edge after release (state FILL). blk_valid=0, blk_data=0, blk_first=0, blk_last=0. cnt, byte_cnt, marker are 0.
- Final byte of a block accepted at edge N → blk_valid=1 after edge N.
- OUT handshake at edge M with next=TAIL → TAIL after M → blk_valid=1 after edge M+1.
- OUT handshake at edge M with next=FILL → in_ready=1 after edge M. There is no bubble beyond the OUT state.
- Full-rate input: 64 bytes take 64 cycles plus ≥1 OUT cycle.
- blk_ready may be high before blk_valid. A block is never emitted in the same cycle a byte is accepted.
- rst_n asserted mid-message or mid-OUT: everything clears immediately, the partial message is discarded, and no block is emitted.

## Configuration
- SHA256_PAD_EMPTY_MSG_EN defined: adds input in_empty (1 bit). In FILL with cnt=0 and byte_cnt=0, an accepted beat with in_empty=1 ignores in_data and in_last and emits one block: byte 0 = 0x80, all else 0, blk_first=1, blk_last=1.
- With cnt≠0, in_empty is ignored.
- Not defined: the port is absent and zero-length messages are unsupported.

## Test plan
- "abc" (0x61,0x62,0x63 with last): one block 0x61626380 followed by zeros with last word 0x00000018; first=1, last=1. The core digest is ba7816bf…f20015ad.
- 55 × 0x61: one block, byte 55=0x80, length 0x1B8. 56 × 0x61: two blocks. The first has byte 56=0x80 and last=0. The second is all zero except length 0x1C0, with first=0, last=1.
- 64 × 0x61: block 1 contains only data (last=0). Block 2 has byte 0=0x80 and length 0x200. blk_valid for block 2 rises 2 cycles after block 1's handshake.
- blk_ready held low for 5 cycles during OUT: blk_data and flags stay stable and in_ready=0 throughout. Then "aaa" is sent back-to-back and its block has blk_first=1.
- rst_n pulsed low after 20 bytes: blk_valid stays 0 and in_ready returns to 1. A following "abc" produces the exact block from the first scenario.
- With SHA256_PAD_EMPTY_MSG_EN, in_empty beat: block 0x80000000 followed by zeros, first=1, last=1. The digest is e3b0c442…7852b855.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: byte stream in, padded 512-bit blocks out with first/last flags.
// Optional zero-length message support is enabled by defining SHA256_PAD_EMPTY_MSG_EN.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 61
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
`ifdef SHA256_PAD_EMPTY_MSG_EN
  input  logic         in_empty,
`endif
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {S_RST, S_FILL, S_OUT, S_TAIL} state_t;

  state_t              r_state;
  logic [0:63][7:0]    r_buf;
  logic [6:0]          r_cnt;
  logic [LEN_W-1:0]    r_byte_cnt;
  logic                r_marker;
  logic                r_next_tail;
  logic                r_first_pend;
  logic                r_in_ready;
  logic                r_blk_valid;
  logic                r_blk_first;
  logic                r_blk_last;

  logic                w_in_fire;
  logic                w_blk_fire;
  logic                w_empty;
  logic [6:0]          w_k;
  logic [LEN_W-1:0]    w_bc_inc;
  logic [63:0]         w_len_fill;
  logic [63:0]         w_len_tail;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_blk_fire = r_blk_valid && blk_ready;
  assign w_k        = r_cnt + 7'd1;
  assign w_bc_inc   = r_byte_cnt + LEN_W'(1);
  assign w_len_fill = 64'({w_bc_inc, 3'b000});
  assign w_len_tail = 64'({r_byte_cnt, 3'b000});

`ifdef SHA256_PAD_EMPTY_MSG_EN
  assign w_empty = in_empty && (r_cnt == 7'd0) && (r_byte_cnt == '0);
`else
  assign w_empty = 1'b0;
`endif

  // Buffer fill, padding insertion and block handshake control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RST;
      r_buf        <= '0;
      r_cnt        <= 7'd0;
      r_byte_cnt   <= '0;
      r_marker     <= 1'b0;
      r_next_tail  <= 1'b0;
      r_first_pend <= 1'b1;
      r_in_ready   <= 1'b0;
      r_blk_valid  <= 1'b0;
      r_blk_first  <= 1'b0;
      r_blk_last   <= 1'b0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
        end

        S_FILL: begin
          if (w_in_fire) begin
            if (w_empty) begin
              r_buf[0]    <= 8'h80;
              r_state     <= S_OUT;
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
              r_blk_first <= r_first_pend;
              r_blk_last  <= 1'b1;
              r_next_tail <= 1'b0;
            end else begin
              r_buf[r_cnt[5:0]] <= in_data;
              r_cnt             <= w_k;
              r_byte_cnt        <= w_bc_inc;
              if (in_last || (w_k == 7'd64)) begin
                r_state     <= S_OUT;
                r_in_ready  <= 1'b0;
                r_blk_valid <= 1'b1;
                r_blk_first <= r_first_pend;
                r_blk_last  <= 1'b0;
                r_next_tail <= 1'b0;
              end
              if (in_last) begin
                if (w_k <= 7'd55) begin
                  r_buf[w_k[5:0]] <= 8'h80;
                  r_buf[56:63]    <= w_len_fill;
                  r_blk_last      <= 1'b1;
                end else if (w_k < 7'd64) begin
                  r_buf[w_k[5:0]] <= 8'h80;
                  r_next_tail     <= 1'b1;
                  r_marker        <= 1'b0;
                end else begin
                  r_next_tail     <= 1'b1;
                  r_marker        <= 1'b1;
                end
              end
            end
          end
        end

        S_OUT: begin
          if (w_blk_fire) begin
            r_buf        <= '0;
            r_cnt        <= 7'd0;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_first_pend <= r_blk_last;
            if (r_blk_last) begin
              r_byte_cnt <= '0;
            end
            if (r_next_tail) begin
              r_state <= S_TAIL;
            end else begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end
          end
        end

        S_TAIL: begin
          r_buf[0]     <= r_marker ? 8'h80 : 8'h00;
          r_buf[56:63] <= w_len_tail;
          r_state      <= S_OUT;
          r_blk_valid  <= 1'b1;
          r_blk_first  <= r_first_pend;
          r_blk_last   <= 1'b1;
          r_next_tail  <= 1'b0;
          r_marker     <= 1'b0;
        end

        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign blk_valid = r_blk_valid;
  assign blk_data  = r_buf;
  assign blk_first = r_blk_first;
  assign blk_last  = r_blk_last;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: vector table plus stall, tail-timing and reset sequences.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
`ifdef SHA256_PAD_EMPTY_MSG_EN
  logic         in_empty;
`endif
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  typedef struct {
    int           len;
    bit           incr;
    int           nblk;
    logic [511:0] e0;
    logic [511:0] e1;
  } vec_t;

  blk_t q[$];

  always #5 clk = ~clk;

  sha256_msg_padder #(.LEN_W(61)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef SHA256_PAD_EMPTY_MSG_EN
    .in_empty  (in_empty),
`endif
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  // Capture every block handshake; also flag overlap of byte and block transfer windows
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) q.push_back('{blk_data, blk_first, blk_last});
    if (rst_n && blk_valid && in_ready) begin
      n_err++;
      $display("FAIL overlap: in_ready=%0b blk_valid=%0b, required not both 1", in_ready, blk_valid);
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: byte %h not accepted, required accept within 300 cycles", d);
    end
  endtask

  task automatic send_msg(input int len, input bit incr);
    for (int i = 0; i < len; i++)
      send_byte(incr ? 8'(8'h61 + i) : 8'h61, i == len - 1);
  endtask

  task automatic wait_blocks(input int n);
    int t = 0;
    while (q.size() < n && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL blk_timeout: got %0d blocks want %0d", q.size(), n);
    end
  endtask

  task automatic pop_chk(input string name, input logic [511:0] e, input logic f, input logic l);
    blk_t b;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_missing: got no block, required one", name);
    end else begin
      b = q.pop_front();
      chk({name, "_data"}, b.d, e);
      chk({name, "_first"}, 512'(b.f), 512'(f));
      chk({name, "_last"}, 512'(b.l), 512'(l));
    end
  endtask

  logic [511:0] e_abc;
  logic [511:0] e_aaa;
  vec_t         vt[7];

  initial begin
    e_abc = {8'h61, 8'h62, 8'h63, 8'h80, 416'd0, 64'h18};
    e_aaa = {8'h61, 8'h61, 8'h61, 8'h80, 416'd0, 64'h18};
    vt[0] = '{3,   1'b1, 1, e_abc, '0};
    vt[1] = '{1,   1'b0, 1, {8'h61, 8'h80, 432'd0, 64'h8}, '0};
    vt[2] = '{55,  1'b0, 1, {{55{8'h61}}, 8'h80, 64'h1B8}, '0};
    vt[3] = '{56,  1'b0, 2, {{56{8'h61}}, 8'h80, 56'd0}, {448'd0, 64'h1C0}};
    vt[4] = '{63,  1'b0, 2, {{63{8'h61}}, 8'h80}, {448'd0, 64'h1F8}};
    vt[5] = '{64,  1'b0, 2, {64{8'h61}}, {8'h80, 440'd0, 64'h200}};
    vt[6] = '{119, 1'b0, 2, {64{8'h61}}, {{55{8'h61}}, 8'h80, 64'h3B8}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    blk_ready = 1'b1;
`ifdef SHA256_PAD_EMPTY_MSG_EN
    in_empty  = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_data", blk_data, '0);
    chk("rst_flags", 512'({blk_first, blk_last}), 512'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));

    // Table-driven messages
    foreach (vt[i]) begin
      send_msg(vt[i].len, vt[i].incr);
      wait_blocks(vt[i].nblk);
      pop_chk($sformatf("v%0d_b0", i), vt[i].e0, 1'b1, vt[i].nblk == 1);
      if (vt[i].nblk == 2) pop_chk($sformatf("v%0d_b1", i), vt[i].e1, 1'b0, 1'b1);
    end

    // Tail block timing for a 64-byte message
    send_msg(64, 1'b0);
    @(negedge clk);
    chk("tail_t0_valid", 512'(blk_valid), 512'(1));
    @(negedge clk);
    chk("tail_t1_valid", 512'(blk_valid), 512'(0));
    @(negedge clk);
    chk("tail_t2_valid", 512'(blk_valid), 512'(1));
    wait_blocks(2);
    pop_chk("tail_b0", {64{8'h61}}, 1'b1, 1'b0);
    pop_chk("tail_b1", {8'h80, 440'd0, 64'h200}, 1'b0, 1'b1);

    // Back-pressure: block held stable while blk_ready is low
    blk_ready = 1'b0;
    send_msg(3, 1'b1);
    for (int t = 0; t < 20 && !blk_valid; t++) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", 512'(blk_valid), 512'(1));
      chk("stall_data", blk_data, e_abc);
      chk("stall_flags", 512'({blk_first, blk_last}), 512'(2'b11));
      chk("stall_in_ready", 512'(in_ready), 512'(0));
    end
    @(posedge clk);
    #1;
    blk_ready = 1'b1;
    send_msg(3, 1'b0);
    wait_blocks(2);
    pop_chk("stall_abc", e_abc, 1'b1, 1'b1);
    pop_chk("stall_aaa", e_aaa, 1'b1, 1'b1);

    // Reset mid-message discards the partial message
    for (int i = 0; i < 20; i++) send_byte(8'h61, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 512'(in_ready), 512'(0));
    chk("mid_rst_blk_valid", 512'(blk_valid), 512'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_in_ready_back", 512'(in_ready), 512'(1));
    chk("mid_rst_no_blk", 512'(blk_valid), 512'(0));
    chk("mid_rst_qsize", 512'(q.size()), 512'(0));
    send_msg(3, 1'b1);
    wait_blocks(1);
    pop_chk("mid_rst_abc", e_abc, 1'b1, 1'b1);

`ifdef SHA256_PAD_EMPTY_MSG_EN
    // Zero-length message
    in_empty = 1'b1;
    send_byte(8'hAA, 1'b0);
    in_empty = 1'b0;
    wait_blocks(1);
    pop_chk("empty", {8'h80, 504'd0}, 1'b1, 1'b1);
`endif

    repeat (3) @(posedge clk);
    chk("final_qsize", 512'(q.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
